// File: rtl/fetch_pkg.sv
// Shared widths, reset PC default and the fetch-buffer entry type for the
// instruction-fetch front end.
package fetch_pkg;
   localparam int INST_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of instruction-memory, redirect and decode signals around the fetch unit.
// Decode handshake: an entry moves when if_valid and if_ready are both high in
// a cycle; if_valid never depends on if_ready, and the head is stable while stalled.
interface inst_fetch_unit_if;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        fetch_fault;

   modport master (
      input  fetch_en, imem_data, redirect_valid, redirect_pc, if_ready,
      output imem_addr, if_valid, if_inst, if_pc, if_pc_plus4, fetch_fault
   );

   modport slave (
      output fetch_en, imem_data, redirect_valid, redirect_pc, if_ready,
      input  imem_addr, if_valid, if_inst, if_pc, if_pc_plus4, fetch_fault
   );
endinterface

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetched {pc, inst} entries with flush and same-cycle push/pop.
// The head reads as zero/NOP whenever the buffer is empty.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  fetch_entry_t             wr_entry,
   output fetch_entry_t             head_entry,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t       mem_q [DEPTH];
   fetch_entry_t       mem_d [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [PTR_W:0]     count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // When full, push+pop writes the slot the head is vacating this cycle.
         if (push) begin
            mem_d[tail_q] = wr_entry;
            tail_d        = tail_q + 1'b1;
         end
         if (pop) head_d = head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   assign head_entry = (count_q == '0) ? '{pc: '0, inst: NOP_INST} : mem_q[head_q];
   assign count      = count_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: owns the PC, fetches one word per cycle into a small buffer
// and handles redirects. Optional macro FETCH_ALIGN_CHECK_EN adds a sticky fault.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int                BUF_DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   inst_fetch_unit_if.master bus
);
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] redirect_target;
   logic [CNT_W-1:0]  count;
   fetch_entry_t      head_entry;
   fetch_entry_t      wr_entry;
   logic              push, pop, fault_halt;

   // A redirect hides the head for the cycle so decode never consumes a stale entry.
   assign bus.if_valid = (count != '0) && !bus.redirect_valid;
   assign pop          = bus.if_valid && bus.if_ready;
   assign push         = bus.fetch_en && !bus.redirect_valid && !fault_halt &&
                         ((count < CNT_W'(BUF_DEPTH)) || pop);
   assign wr_entry     = '{pc: pc_q, inst: bus.imem_data};

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q, fault_d;

   always_comb begin
      fault_d = fault_q;
      if (bus.redirect_valid) fault_d = |bus.redirect_pc[1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) fault_q <= 1'b0;
      else     fault_q <= fault_d;
   end

   assign fault_halt      = fault_q;
   assign bus.fetch_fault = fault_q;
   assign redirect_target = bus.redirect_pc;
`else
   logic unused_low_bits;

   assign unused_low_bits = ^bus.redirect_pc[1:0];
   assign fault_halt      = 1'b0;
   assign bus.fetch_fault = 1'b0;
   assign redirect_target = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
`endif

   always_comb begin
      pc_d = pc_q;
      if (bus.redirect_valid) pc_d = redirect_target;
      else if (push)          pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.redirect_valid),
      .push       (push),
      .pop        (pop),
      .wr_entry   (wr_entry),
      .head_entry (head_entry),
      .count      (count)
   );

   assign bus.imem_addr   = pc_q;
   assign bus.if_inst     = head_entry.inst;
   assign bus.if_pc       = head_entry.pc;
   assign bus.if_pc_plus4 = (count != '0) ? head_entry.pc + 32'd4 : '0;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed test-plan sequences then random traffic,
// scored against a queue-based model of the fetch buffer and PC.
module tb_inst_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 2;

   logic clk;
   logic rst;
   inst_fetch_unit_if bus ();

   inst_fetch_unit #(
      .RESET_PC  (RST_PC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000 + (a >> 2);
   endfunction

   assign bus.imem_data = mem_word(bus.imem_addr);

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model state and scoreboard
   logic [63:0] m_q[$];
   logic [63:0] exp_q[$];
   logic [31:0] m_pc;
   logic        m_fault;
   logic [31:0] exp_addr;
   logic        exp_valid, exp_empty, exp_fault;
   logic        chk_en;
   int          n_cmp, n_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: applies one cycle of inputs and advances the reference model
   task automatic step(input logic r, input logic fen, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
      int   sz;
      logic pop, push;
      @(negedge clk);
      rst                = r;
      bus.fetch_en       = fen;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.if_ready       = rdy;
      sz        = m_q.size();
      exp_addr  = m_pc;
      exp_fault = m_fault;
      exp_empty = (sz == 0);
      exp_valid = (sz > 0) && !rv;
      pop       = exp_valid && rdy && !r;
      if (pop) exp_q.push_back(m_q[0]);
      push = fen && !rv && !m_fault && ((sz < DEPTH) || pop);
      if (r) begin
         m_q.delete();
         m_pc    = RST_PC;
         m_fault = 1'b0;
      end else if (rv) begin
         m_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
         m_pc    = rpc;
         m_fault = (rpc[1:0] != 2'b00);
`else
         m_pc    = {rpc[31:2], 2'b00};
`endif
      end else begin
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic run(input int n, input logic fen, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, fen, 1'b0, 32'h0, rdy);
   endtask

   // monitor: samples settled outputs and pops the scoreboard on each handshake
   always @(negedge clk) begin
      logic [63:0] e;
      #1;
      if (chk_en) begin
         chk("imem_addr", bus.imem_addr, exp_addr);
         chk("if_valid", {31'h0, bus.if_valid}, {31'h0, exp_valid});
         chk("fetch_fault", {31'h0, bus.fetch_fault}, {31'h0, exp_fault});
         if (exp_empty) begin
            chk("empty_if_pc", bus.if_pc, 32'h0);
            chk("empty_if_inst", bus.if_inst, 32'h0);
            chk("empty_if_pc_plus4", bus.if_pc_plus4, 32'h0);
         end
         if (bus.if_valid && bus.if_ready && !rst) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_delivery", bus.if_pc, 32'hxxxx_xxxx);
            end else begin
               e = exp_q.pop_front();
               chk("if_pc", bus.if_pc, e[63:32]);
               chk("if_inst", bus.if_inst, e[31:0]);
               chk("if_pc_plus4", bus.if_pc_plus4, e[63:32] + 32'd4);
            end
         end
         chk("missed_delivery", exp_q.size(), 0);
         exp_q.delete();
      end
   end

   initial begin
      logic [31:0] rpc;
      n_cmp              = 0;
      n_err              = 0;
      chk_en             = 1'b0;
      rst                = 1'b1;
      bus.fetch_en       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.if_ready       = 1'b0;
      m_pc               = RST_PC;
      m_fault            = 1'b0;
      chk_en             = 1'b1;

      // reset, then streaming from RESET_PC
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      run(6, 1'b1, 1'b1);

      // decode stall: buffer fills, PC holds, then in-order drain
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      run(1, 1'b1, 1'b1);
      run(5, 1'b1, 1'b0);
      run(4, 1'b1, 1'b1);

      // redirect while full
      run(4, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
      run(4, 1'b1, 1'b1);

      // redirect near the top of the address space, PC wraps to 0
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      run(5, 1'b1, 1'b1);

      // reset during streaming and during a redirect cycle
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      run(4, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
      run(3, 1'b1, 1'b1);

      // misaligned redirect, then an aligned one
      step(1'b0, 1'b1, 1'b1, 32'h0000_0042, 1'b1);
      run(4, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b1);
      run(4, 1'b1, 1'b1);

      // fetch disabled: buffer drains, PC holds
      run(3, 1'b1, 1'b0);
      run(4, 1'b0, 1'b1);
      run(2, 1'b1, 1'b1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       rpc = $urandom & 32'h0000_0FFC;
            1:       rpc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
            2:       rpc = $urandom;
            default: rpc = $urandom & 32'h0000_0FFF;
         endcase
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 99) < 85),
              ($urandom_range(0, 9) == 0),
              rpc,
              ($urandom_range(0, 99) < 70));
      end

      run(2, 1'b0, 1'b1);
      @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch front end. It owns the PC and drives the word-addressed instruction memory read port. The memory returns data in the same cycle; this unit captures that data and presents {pc, inst} to decode through a valid/ready interface. It holds a 2-entry fetch buffer that absorbs decode stalls, and it accepts jump/branch redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUF_DEPTH, 2, fetch-buffer entries; must be a power of two and at least 2.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
fetch_en  in  1  when 0, no new fetches are issued; the buffer still drains.
imem_addr  out  32  byte address to instruction memory; always equals the PC register.
imem_data  in  32  instruction word for imem_addr, combinational, valid in the same cycle.
redirect_valid  in  1  jump/branch taken this cycle.
redirect_pc  in  32  target byte address.
if_valid  out  1  buffer head is valid for decode.
if_ready  in  1  decode accepts the head this cycle.
if_inst  out  32  head instruction.
if_pc  out  32  head PC.
if_pc_plus4  out  32  head PC + 4, mod 2^32.
fetch_fault  out  1  sticky misaligned-target flag; see Optional Feature.

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - pc = RESET_PC; buffer count = 0; if_valid = 0; fetch_fault = 0.
  - if_inst, if_pc and if_pc_plus4 read 0 while the buffer is empty.
- Definitions (per cycle):
  - pop = if_valid & if_ready & ~redirect_valid.
  - push = fetch_en & ~redirect_valid & ~fault_halt & (count < BUF_DEPTH | pop).
- Push action: write {pc, imem_data} at the buffer tail, then pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0).
- Push and pop in the same cycle: count is unchanged and order is preserved; this also applies when the buffer is full.
- Latency:
  - With rst deasserted at cycle 0 and fetch_en = 1, RESET_PC is pushed at the end of cycle 0 and if_valid = 1 in cycle 1.
  - Steady state: one instruction per cycle while if_ready = 1.
- Redirect (highest priority):
  - In the redirect cycle, if_valid is forced to 0 combinationally and the head is not consumed.
  - At the clock edge: count <= 0, pc <= redirect_pc (subject to the alignment rule), no push.
  - The target instruction is valid 2 cycles after the redirect cycle.
  - A redirect while the buffer is full or empty behaves identically.
- fetch_en = 0: pc is held and the buffer drains; if_valid falls once count reaches 0.
- Decode stall (if_ready = 0): the head and its outputs stay stable. The buffer fills to BUF_DEPTH, then pc holds.
- Reset asserted mid-stream: rst overrides redirect, push and pop; the next cycle shows reset state.
- if_valid depends only on count and redirect_valid, never on if_ready.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - A redirect_pc with bits [1:0] != 0 sets fetch_fault and fault_halt; pc <= redirect_pc unmodified; no further pushes.
  - fetch_fault stays set until rst or the next aligned redirect, which clears it.
- Undefined:
  - pc <= {redirect_pc[31:2], 2'b00}; fetch_fault is tied to 0; fault_halt is constant 0.

Decomposition:
- fetch_pkg:
  - INST_W = 32, ADDR_W = 32, default RESET_PC.
  - fetch_entry_t struct {pc[31:0], inst[31:0]}.
  - NOP_INST = 32'h0000_0000.
- Sub-module fetch_buffer: circular FIFO with BUF_DEPTH entries, head/tail pointers, count, flush input, and simultaneous push/pop support. inst_fetch_unit holds the PC, push/pop control and fault logic.

Test Plan:
1. Reset with RESET_PC = 0, memory word i = 0x1000 + i, if_ready = 1 → cycle 1 shows if_pc = 0 / if_inst = 0x1000, then pc 4, 8, 12 with one instruction per cycle.
2. Hold if_ready = 0 for 5 cycles after the first valid → if_pc stays 0; imem_addr stops at 8 once 2 entries are buffered. Releasing if_ready delivers pcs 0, 4, 8 in order with no gap.
3. Redirect to 0x40 while the buffer is full → if_valid = 0 that cycle; the next cycle is empty; then if_pc = 0x40, if_pc_plus4 = 0x44; entries for 4 and 8 are never delivered.
4. Redirect to 0xFFFF_FFFC → delivered pcs are 0xFFFF_FFFC, then 0x0000_0000 (wrap).
5. Assert rst during streaming and during a redirect cycle → the next cycle has if_valid = 0 and pc = RESET_PC.
6. Redirect to 0x42: with FETCH_ALIGN_CHECK_EN defined, fetch_fault = 1 and no valid output until a redirect to 0x80 clears it; without the macro, if_pc = 0x40.
